pipe_stage_buf: RTL and testbench

//  Generic inter-stage pipeline register (D2E/E2M/M2W successor) with valid/ready handshake and flush.

---
 rtl/pipe_stage_buf_pkg.sv | 27 ++
 rtl/pipe_stage_buf_if.sv | 13 +
 rtl/pipe_stage_buf_sat_counter.sv | 25 ++
 rtl/pipe_stage_buf.sv | 120 ++++++++++++
 tb/tb_pipe_stage_buf.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared types and constants for the pipeline stage buffer.
// Holds the occupancy state encoding and the payload field indices.
package pipe_pkg;

  // Buffer occupancy: no entries, main valid, main and skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Payload lane indices. Field k lives at [k*DATA_W +: DATA_W].
  localparam int F_INSTR = 0;
  localparam int F_PC    = 1;
  localparam int F_PC8   = 2;
  localparam int F_RS    = 3;
  localparam int F_RT    = 4;
  localparam int F_ALU_C = 5;
  localparam int F_EXT   = 6;
  localparam int F_FLAGS = 7;

  // Bit offset of lane k for a given lane width.
  function automatic int field_lsb(input int k, input int data_w);
    return k * data_w;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// One valid/ready/data channel between pipeline stages.
// master drives valid/data, slave drives ready.
interface pipe_stage_buf_if #(
  parameter int DATA_W     = 32,
  parameter int NUM_FIELDS = 8
);
  logic                         valid;
  logic                         ready;
  logic [NUM_FIELDS*DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter used for the optional stage statistics.
// Clears on synchronous reset, sticks at all-ones.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count qualifying cycles, holding once the maximum is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline register with a two-entry skid buffer.
// Full throughput with a registered upstream ready; flush kills all held
// entries. Optional stall/bubble statistics are built when the macro
// PIPE_STAGE_STATS_EN is defined; otherwise those ports do not exist.
//
// state | meaning
// EMPTY | no payload held, out_valid low
// BUSY  | main entry valid, skid free
// FULL  | main and skid valid, upstream ready low
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_FIELDS = 8
`ifdef PIPE_STAGE_STATS_EN
  , parameter int CNT_W    = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_buf_if.slave  up,
  pipe_stage_buf_if.master dn
`ifdef PIPE_STAGE_STATS_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  localparam int BUS_W = NUM_FIELDS * DATA_W;

  state_e           state_q, state_d;
  logic [BUS_W-1:0] main_q, main_d;
  logic [BUS_W-1:0] skid_q, skid_d;
  logic             in_fire;
  logic             out_fire;
  logic             out_valid;

  // Both handshake flags come straight from the state register.
  assign up.ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign dn.valid  = out_valid;
  assign dn.data   = main_q;

  // State and both entries; all payload lanes move together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and entry updates; flush overrides any handshake.
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    in_fire  = up.valid && (state_q != FULL);
    out_fire = out_valid && dn.ready;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = BUSY;
            main_d  = up.data;
          end
        end
        BUSY: begin
          if (in_fire && !out_fire) begin
            state_d = FULL;
            skid_d  = up.data;
          end else if (!in_fire && out_fire) begin
            state_d = EMPTY;
          end else if (in_fire && out_fire) begin
            main_d = up.data;
          end
        end
        FULL: begin
          // Older skid payload must reach main before any new input.
          if (out_fire) begin
            state_d = BUSY;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  // Flush deliberately leaves the statistics untouched.
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid && !dn.ready),
    .cnt_o (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!out_valid),
    .cnt_o (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
// Statistics checks are compiled when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int DATA_W     = 32;
  localparam int NUM_FIELDS = 8;
  localparam int BUS_W      = DATA_W * NUM_FIELDS;
  localparam int CNT_W      = 4;

  logic clk;
  logic reset;
  logic flush;

  pipe_stage_buf_if #(.DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS)) up_if ();
  pipe_stage_buf_if #(.DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS)) dn_if ();

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
`endif

  pipe_stage_buf #(
    .DATA_W     (DATA_W),
    .NUM_FIELDS (NUM_FIELDS)
`ifdef PIPE_STAGE_STATS_EN
    , .CNT_W    (CNT_W)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .up    (up_if),
    .dn    (dn_if)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Reference model: list of held payloads, oldest first, at most two.
  logic [BUS_W-1:0] mq[$];
  int m_stall  = 0;
  int m_bubble = 0;

  task automatic chk(input string name, input logic [BUS_W-1:0] act,
                     input logic [BUS_W-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Field k of a test payload carries the tag in its upper bits and k below.
  function automatic logic [BUS_W-1:0] mk(input int tag);
    logic [BUS_W-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      v[field_lsb(k, DATA_W) +: DATA_W] = (32'(tag) << 8) | 32'(k);
    end
    return v;
  endfunction

  // Model update on every edge from the inputs as they stood before it.
  always @(posedge clk) begin
    bit had_entry;
    bit do_in;
    bit do_out;
    had_entry = (mq.size() > 0);
    if (reset) begin
      mq.delete();
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (had_entry && !dn_if.ready && m_stall < (2**CNT_W - 1)) m_stall++;
      if (!had_entry && m_bubble < (2**CNT_W - 1)) m_bubble++;
      if (flush) begin
        mq.delete();
      end else begin
        do_out = had_entry && dn_if.ready;
        do_in  = up_if.valid && (mq.size() < 2);
        if (do_out) void'(mq.pop_front());
        if (do_in) mq.push_back(up_if.data);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("sb_out_valid", BUS_W'(dn_if.valid), BUS_W'(mq.size() > 0));
      chk("sb_in_ready", BUS_W'(up_if.ready), BUS_W'(mq.size() < 2));
      if (mq.size() > 0) chk("sb_out_data", dn_if.data, mq[0]);
`ifdef PIPE_STAGE_STATS_EN
      chk("sb_stall_cnt", BUS_W'(stall_cnt), BUS_W'(m_stall));
      chk("sb_bubble_cnt", BUS_W'(bubble_cnt), BUS_W'(m_bubble));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [BUS_W-1:0] d, input bit ordy);
    up_if.valid = v;
    up_if.data  = d;
    dn_if.ready = ordy;
  endtask

  task automatic expect_out(input string name, input bit v, input bit irdy,
                            input logic [BUS_W-1:0] d);
    chk({name, "_valid"}, BUS_W'(dn_if.valid), BUS_W'(v));
    chk({name, "_in_ready"}, BUS_W'(up_if.ready), BUS_W'(irdy));
    chk({name, "_data"}, dn_if.data, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] pat_v;
    logic [15:0] pat_r;
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, '0, 1'b0);

    // 1: reset held two cycles.
    tick();
    check_en = 1'b1;
    tick();
    expect_out("reset", 1'b0, 1'b1, '0);
    chk("reset_instr_nop", dn_if.data[field_lsb(F_INSTR, DATA_W) +: DATA_W], '0);
`ifdef PIPE_STAGE_STATS_EN
    chk("reset_stall_cnt", BUS_W'(stall_cnt), '0);
    chk("reset_bubble_cnt", BUS_W'(bubble_cnt), '0);
`endif
    reset = 1'b0;

    // 2: streaming, one payload per cycle, one cycle latency.
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, mk(i), 1'b1);
      tick();
      expect_out($sformatf("stream%0d", i), 1'b1, 1'b1, mk(i));
    end
    drive(1'b0, '0, 1'b1);
    tick();
    chk("stream_drained", BUS_W'(dn_if.valid), '0);

    // 3: stall with A,B,C offered; then release and retry C.
    drive(1'b1, mk(16'hA), 1'b0);
    tick();
    expect_out("stallA", 1'b1, 1'b1, mk(16'hA));
    drive(1'b1, mk(16'hB), 1'b0);
    tick();
    expect_out("stallB", 1'b1, 1'b0, mk(16'hA));
    drive(1'b1, mk(16'hC), 1'b0);
    tick();
    expect_out("stallC", 1'b1, 1'b0, mk(16'hA));
    drive(1'b1, mk(16'hC), 1'b1);
    tick();
    expect_out("releaseB", 1'b1, 1'b1, mk(16'hB));
    drive(1'b1, mk(16'hC), 1'b1);
    tick();
    expect_out("releaseC", 1'b1, 1'b1, mk(16'hC));
    drive(1'b0, '0, 1'b1);
    tick();
    chk("release_empty", BUS_W'(dn_if.valid), '0);

    // 4: flush while FULL with a competing in_fire.
    drive(1'b1, mk(16'hE), 1'b0);
    tick();
    drive(1'b1, mk(16'hF), 1'b0);
    tick();
    chk("full_before_flush", BUS_W'(up_if.ready), '0);
    flush = 1'b1;
    drive(1'b1, mk(16'h6), 1'b1);
    tick();
    flush = 1'b0;
    expect_out("flush", 1'b0, 1'b1, '0);
    drive(1'b0, '0, 1'b0);
    tick();
    chk("flush_stays_empty", BUS_W'(dn_if.valid), '0);

    // 5: reset while FULL, then payload D goes through.
    drive(1'b1, mk(16'h11), 1'b0);
    tick();
    drive(1'b1, mk(16'h12), 1'b0);
    tick();
    reset = 1'b1;
    drive(1'b0, '0, 1'b0);
    tick();
    reset = 1'b0;
    expect_out("reset_full", 1'b0, 1'b1, '0);
    drive(1'b1, mk(16'hD), 1'b1);
    tick();
    expect_out("after_reset_D", 1'b1, 1'b1, mk(16'hD));
    drive(1'b0, '0, 1'b1);
    tick();
    chk("after_reset_empty", BUS_W'(dn_if.valid), '0);

    // Mixed handshake patterns, checked by the model only.
    pat_v = 16'b1101_1011_1110_0111;
    pat_r = 16'b1011_0110_1101_1100;
    for (int i = 0; i < 16; i++) begin
      drive(pat_v[i], mk(16'h100 + i), pat_r[i]);
      tick();
    end
    drive(1'b0, '0, 1'b1);
    tick();
    tick();

`ifdef PIPE_STAGE_STATS_EN
    // 6: long stall saturates the 4-bit stall counter.
    drive(1'b1, mk(16'h55), 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    repeat (20) tick();
    chk("stall_saturated", BUS_W'(stall_cnt), BUS_W'(15));
    drive(1'b0, '0, 1'b1);
    tick();
`endif

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
